// File: rtl/grad_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grad_seq_pkg
//  Description : Shared constants, channel codes and state encoding for the
//                gradient update sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package grad_seq_pkg;

  // Default channel word width, matching the downstream DAC interface.
  localparam int DATA_W_DEFAULT = 24;

  // One committed set carries all four channels.
  localparam int SET_W = 4 * DATA_W_DEFAULT;

  // Channel select codes on wr_chan_i.
  localparam logic [1:0] CH_X  = 2'd0;
  localparam logic [1:0] CH_Y  = 2'd1;
  localparam logic [1:0] CH_Z  = 2'd2;
  localparam logic [1:0] CH_Z2 = 2'd3;

  // Release sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/grad_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : grad_seq_fifo
//  Description : Synchronous first-word fall-through FIFO of gradient sets.
//                The head entry is always presented on rd_data; pop advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_seq_fifo
  import grad_seq_pkg::*;
#(
  parameter int WIDTH = SET_W,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Count never exceeds DEPTH, so its MSB alone marks the full condition.
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/grad_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : grad_update_sequencer
//  Description : Stages per-channel gradient writes, queues committed sets and
//                releases one set per update interval to the DAC interface,
//                flagging underruns when a release is due but nothing queued.
//  Options     : GRAD_UNDERRUN_CNT_EN adds a saturating underrun event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_update_sequencer
  import grad_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_AW    = 4,
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [1:0]            wr_chan_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_commit_i,
  output logic                  wr_ready_o,
  input  logic                  run_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic                  underrun_clr_i,
  input  logic                  busy_i,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     datax_o,
  output logic [DATA_W-1:0]     datay_o,
  output logic [DATA_W-1:0]     dataz_o,
  output logic [DATA_W-1:0]     dataz2_o,
  output logic [FIFO_AW:0]      fifo_level_o,
  output logic                  underrun_o
`ifdef GRAD_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt_o
`endif
);

  localparam int SET_BITS = 4 * DATA_W;

  seq_state_t            state, state_n;
  logic [INTERVAL_W-1:0] timer, timer_n;
  logic [INTERVAL_W-1:0] load_val;
  logic                  expire;
  logic                  pop;
  logic                  ur_set;

  logic [DATA_W-1:0]     stage_x, stage_y, stage_z, stage_z2;
  logic [DATA_W-1:0]     next_x, next_y, next_z, next_z2;
  logic                  wr_accept;
  logic                  push;
  logic [SET_BITS-1:0]   push_data;
  logic [SET_BITS-1:0]   head_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign wr_ready_o = ~fifo_full;
  assign wr_accept  = wr_valid_i & wr_ready_o;
  assign push       = wr_accept & wr_commit_i;
  assign push_data  = {next_z2, next_z, next_y, next_x};

  // A zero interval behaves as one: release every cycle.
  assign load_val = (interval_i == '0) ? '0 : interval_i - 1'b1;
  assign expire   = (timer == '0);

  // Staging view with the current accepted write merged in.
  always_comb begin
    next_x  = stage_x;
    next_y  = stage_y;
    next_z  = stage_z;
    next_z2 = stage_z2;
    if (wr_accept) begin
      case (wr_chan_i)
        CH_X:  next_x  = wr_data_i;
        CH_Y:  next_y  = wr_data_i;
        CH_Z:  next_z  = wr_data_i;
        CH_Z2: next_z2 = wr_data_i;
      endcase
    end
  end

  // Staging registers keep their values across commits for partial updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_x  <= '0;
      stage_y  <= '0;
      stage_z  <= '0;
      stage_z2 <= '0;
    end else begin
      stage_x  <= next_x;
      stage_y  <= next_y;
      stage_z  <= next_z;
      stage_z2 <= next_z2;
    end
  end

  grad_seq_fifo #(
    .WIDTH (SET_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_o)
  );

  // State and period timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // Next-state, timer reload and release/underrun decisions.
  always_comb begin
    state_n = state;
    timer_n = timer;
    pop     = 1'b0;
    ur_set  = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (run_i) begin
          timer_n = load_val;
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (!run_i) begin
          timer_n = '0;
          state_n = IDLE;
        end else if (expire) begin
          // Reload on every expiry so the period never drifts.
          timer_n = load_val;
          if (fifo_empty)  ur_set  = 1'b1;
          else if (busy_i) state_n = PEND;
          else             pop     = 1'b1;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      PEND: begin
        // Keep the period running; an expiry here cannot be served.
        if (run_i) begin
          if (expire) begin
            timer_n = load_val;
            ur_set  = 1'b1;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        if (!busy_i) begin
          pop = 1'b1;
          if (run_i) begin
            state_n = COUNT;
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Release outputs: one-cycle valid with data captured on the popping edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      datax_o  <= '0;
      datay_o  <= '0;
      dataz_o  <= '0;
      dataz2_o <= '0;
    end else begin
      valid_o <= pop;
      if (pop) begin
        datax_o  <= head_data[0*DATA_W +: DATA_W];
        datay_o  <= head_data[1*DATA_W +: DATA_W];
        dataz_o  <= head_data[2*DATA_W +: DATA_W];
        dataz2_o <= head_data[3*DATA_W +: DATA_W];
      end
    end
  end

  // Sticky underrun flag; a new event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)              underrun_o <= 1'b0;
    else if (ur_set)         underrun_o <= 1'b1;
    else if (underrun_clr_i) underrun_o <= 1'b0;
  end

`ifdef GRAD_UNDERRUN_CNT_EN
  // Saturating underrun event counter; set with clear restarts at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt_o <= '0;
    end else if (ur_set) begin
      if (underrun_clr_i)                underrun_cnt_o <= 16'd1;
      else if (underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end else if (underrun_clr_i) begin
      underrun_cnt_o <= '0;
    end
  end
`else
  // Underrun counting disabled: only the sticky flag is provided.
`endif

endmodule
`default_nettype wire

// File: tb/tb_grad_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grad_update_sequencer
//  Description : Directed self-checking bench for grad_update_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_grad_update_sequencer;
  import grad_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] wr_data_i = '0;
  logic [1:0]  wr_chan_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_commit_i = 1'b0;
  logic        wr_ready_o;
  logic        run_i = 1'b0;
  logic [15:0] interval_i = '0;
  logic        underrun_clr_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        valid_o;
  logic [23:0] datax_o, datay_o, dataz_o, dataz2_o;
  logic [4:0]  fifo_level_o;
  logic        underrun_o;
`ifdef GRAD_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  grad_update_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data_i      (wr_data_i),
    .wr_chan_i      (wr_chan_i),
    .wr_valid_i     (wr_valid_i),
    .wr_commit_i    (wr_commit_i),
    .wr_ready_o     (wr_ready_o),
    .run_i          (run_i),
    .interval_i     (interval_i),
    .underrun_clr_i (underrun_clr_i),
    .busy_i         (busy_i),
    .valid_o        (valid_o),
    .datax_o        (datax_o),
    .datay_o        (datay_o),
    .dataz_o        (dataz_o),
    .dataz2_o       (dataz2_o),
    .fifo_level_o   (fifo_level_o),
    .underrun_o     (underrun_o)
`ifdef GRAD_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Release log: data and the posedge index that produced each valid pulse.
  logic [95:0] rel_d[$];
  int          rel_t[$];
  always @(negedge clk) begin
    if (valid_o) begin
      rel_d.push_back({dataz2_o, dataz_o, datay_o, datax_o});
      rel_t.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [23:0] d, input logic cm);
    wr_chan_i   = ch;
    wr_data_i   = d;
    wr_valid_i  = 1'b1;
    wr_commit_i = cm;
    step();
    wr_valid_i  = 1'b0;
    wr_commit_i = 1'b0;
  endtask

  task automatic clr_pulse();
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
  endtask

  task automatic chk_rel(input string tag, input int idx,
                         input logic [23:0] x, input logic [23:0] y,
                         input logic [23:0] z, input logic [23:0] z2);
    logic [95:0] d;
    if (idx >= rel_d.size()) begin
      check({tag, "_present"}, rel_d.size(), idx + 1);
    end else begin
      d = rel_d[idx];
      check({tag, "_x"},  d[23:0],  x);
      check({tag, "_y"},  d[47:24], y);
      check({tag, "_z"},  d[71:48], z);
      check({tag, "_z2"}, d[95:72], z2);
    end
  endtask

  int base;
  int c0;

  initial begin
    // Reset state
    step(3);
    rst_n = 1'b1;
    step();
    check("rst_valid", valid_o, 0);
    check("rst_datax", datax_o, 0);
    check("rst_dataz2", dataz2_o, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_ready", wr_ready_o, 1);
    check("rst_underrun", underrun_o, 0);

    // Single set, interval 10: release at expiry+1, later expiries underrun
    wr(CH_X, 24'd1, 1'b0);
    wr(CH_Y, 24'd2, 1'b0);
    wr(CH_Z, 24'd3, 1'b0);
    wr(CH_Z2, 24'd4, 1'b1);
    check("t1_level", fifo_level_o, 1);
    base = rel_d.size();
    interval_i = 16'd10;
    run_i = 1'b1;
    c0 = cyc;
    step(30);
    check("t1_count", rel_d.size() - base, 1);
    if (rel_t.size() > base) check("t1_latency", rel_t[base] - c0, 11);
    chk_rel("t1", base, 24'd1, 24'd2, 24'd3, 24'd4);
    check("t1_underrun", underrun_o, 1);
    run_i = 1'b0;
    step();
    clr_pulse();
    check("t1_clr", underrun_o, 0);

    // Fill to 16, dropped 17th write, drain at interval 0
    for (int i = 0; i < 16; i++) begin
      wr(CH_X,  24'h100 + 24'(i), 1'b0);
      wr(CH_Y,  24'h200 + 24'(i), 1'b0);
      wr(CH_Z,  24'h300 + 24'(i), 1'b0);
      wr(CH_Z2, 24'h400 + 24'(i), 1'b1);
    end
    check("t2_full_ready", wr_ready_o, 0);
    check("t2_full_level", fifo_level_o, 16);
    wr(CH_X, 24'hDEAD, 1'b1);
    check("t2_drop_level", fifo_level_o, 16);
    base = rel_d.size();
    interval_i = 16'd0;
    run_i = 1'b1;
    c0 = cyc;
    step(25);
    check("t2_count", rel_d.size() - base, 16);
    if (rel_t.size() >= base + 16) begin
      check("t2_latency", rel_t[base] - c0, 2);
      check("t2_spacing", rel_t[base + 15] - rel_t[base], 15);
    end
    for (int i = 0; i < 16; i++)
      chk_rel($sformatf("t2_set%0d", i), base + i,
              24'h100 + 24'(i), 24'h200 + 24'(i), 24'h300 + 24'(i), 24'h400 + 24'(i));
    check("t2_level0", fifo_level_o, 0);
    check("t2_underrun", underrun_o, 1);
`ifdef GRAD_UNDERRUN_CNT_EN
    check("t2_cnt_nz", underrun_cnt_o != 16'd0, 1);
`endif
    run_i = 1'b0;
    step();
    clr_pulse();
    check("t2_clr", underrun_o, 0);
`ifdef GRAD_UNDERRUN_CNT_EN
    check("t2_cnt_clr", underrun_cnt_o, 0);
`endif

    // Partial commit of Y only; dropped write must not have touched X
    wr(CH_Y, 24'h00ABCD, 1'b1);
    base = rel_d.size();
    interval_i = 16'd3;
    run_i = 1'b1;
    step(8);
    run_i = 1'b0;
    check("t3_count", rel_d.size() - base, 1);
    chk_rel("t3", base, 24'h10F, 24'h00ABCD, 24'h30F, 24'h40F);
    step();
    clr_pulse();

    // busy across an expiry: PEND, lost expiry, release when busy drops
    wr(CH_X, 24'd5, 1'b0);
    wr(CH_Y, 24'd6, 1'b0);
    wr(CH_Z, 24'd7, 1'b0);
    wr(CH_Z2, 24'd8, 1'b1);
    clr_pulse();
    base = rel_d.size();
    busy_i = 1'b1;
    interval_i = 16'd10;
    run_i = 1'b1;
    c0 = cyc;
    step(15);
    check("t4_pend_hold", rel_d.size() - base, 0);
    check("t4_pend_no_ur", underrun_o, 0);
    step(10);
    busy_i = 1'b0;
    step(4);
    check("t4_count", rel_d.size() - base, 1);
    if (rel_t.size() > base) check("t4_latency", rel_t[base] - c0, 26);
    chk_rel("t4", base, 24'd5, 24'd6, 24'd7, 24'd8);
    check("t4_underrun", underrun_o, 1);
    run_i = 1'b0;
    step(2);

    // Reset during PEND aborts the release
    clr_pulse();
    wr(CH_X, 24'd9, 1'b1);
    base = rel_d.size();
    busy_i = 1'b1;
    interval_i = 16'd2;
    run_i = 1'b1;
    step(6);
    check("t5_pend_hold", rel_d.size() - base, 0);
    rst_n = 1'b0;
    busy_i = 1'b0;
    run_i = 1'b0;
    step();
    rst_n = 1'b1;
    step(5);
    check("t5_no_pulse", rel_d.size() - base, 0);
    check("t5_level", fifo_level_o, 0);
    check("t5_datax", datax_o, 0);
    check("t5_datay", datay_o, 0);
    check("t5_dataz", dataz_o, 0);
    check("t5_dataz2", dataz2_o, 0);
    check("t5_underrun", underrun_o, 0);
    check("t5_ready", wr_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
